divisor_reloj_multicanal: RTL and testbench

Multi-channel programmable clock divider and LED driver that replaces the single fixed-rate test divider in the hexadecimal-decoder design. It generates independent periodic ticks and LED waveforms for `CANALES` channels, each with a runtime-loadable divide value and output mode. It sits between the board clock and the display/LED logic, supplying both the multiplex strobes (`Tick`) and the visible blink signals (`Led`).

---
 rtl/divisor_reloj_multicanal.sv | 108 ++++++++++
 tb/tb_divisor_reloj_multicanal.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_reloj_multicanal.sv
// divisor_reloj_multicanal: multi-channel programmable clock divider.
// Each channel produces a registered one-cycle wrap strobe (Tick) and an
// LED waveform (Led) whose shape depends on a runtime-loadable mode.
//
// Ports:
//   Clock       in  1      system clock, rising edge
//   Reset       in  1      asynchronous, active-high reset
//   Habilitar   in  1      global count enable (low freezes all counters)
//   CargarCanal in  1      single-cycle load strobe
//   SelCanal    in  SEL_W  channel index for a load
//   Divisor     in  ANCHO  new terminal count for the selected channel
//   Modo        in  2      new mode: 00 off, 01 toggle, 10 pulse, 11 on
//   Led         out CANALES per-channel registered LED output
//   Tick        out CANALES per-channel registered wrap strobe

module divisor_reloj_multicanal #(
    parameter int          CANALES     = 4,
    parameter int          ANCHO       = 26,
    parameter int unsigned DIV_DEFAULT = 24999999,
    parameter int          SEL_W       = (CANALES > 1) ? $clog2(CANALES) : 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Habilitar,
    input  logic               CargarCanal,
    input  logic [SEL_W-1:0]   SelCanal,
    input  logic [ANCHO-1:0]   Divisor,
    input  logic [1:0]         Modo,
    output logic [CANALES-1:0] Led,
    output logic [CANALES-1:0] Tick
);

    // Reset terminal count, truncated to the counter width.
    localparam logic [ANCHO-1:0] LIM_RST = ANCHO'(DIV_DEFAULT);
    localparam logic [ANCHO-1:0] UNO     = ANCHO'(1);

    localparam logic [1:0] M_OFF = 2'b00;
    localparam logic [1:0] M_TOG = 2'b01;
    localparam logic [1:0] M_PUL = 2'b10;
    localparam logic [1:0] M_ON  = 2'b11;

    // A load naming a channel that does not exist is dropped here, so no
    // channel ever sees it.
    logic carga_valida;
    assign carga_valida = CargarCanal && (32'(SelCanal) < 32'(CANALES));

    for (genvar g = 0; g < CANALES; g++) begin : g_canal
        logic [ANCHO-1:0] limite;
        logic [ANCHO-1:0] contador;
        logic [ANCHO-1:0] contador_d;
        logic [1:0]       modo;
        logic             led_q;
        logic             led_d;
        logic             tick_q;
        logic             tick_d;
        logic             carga;
        logic             wrap;

        assign carga = carga_valida && (32'(SelCanal) == 32'(g));

        // Equality wrap keeps contador <= limite; with limite at the
        // all-ones value the wrap still lands on zero.
        assign wrap = (contador == limite);

        // Free-running behaviour; a load overrides it in the register.
        always_comb begin
            contador_d = contador;
            tick_d     = 1'b0;
            led_d      = led_q;
            if (Habilitar) begin
                tick_d     = wrap;
                contador_d = wrap ? '0 : contador + UNO;
                case (modo)
                    M_OFF:   led_d = 1'b0;
                    M_TOG:   led_d = led_q ^ wrap;
                    M_PUL:   led_d = wrap;
                    M_ON:    led_d = 1'b1;
                    default: led_d = 1'b0;
                endcase
            end
        end

        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                limite   <= LIM_RST;
                modo     <= M_TOG;
                contador <= '0;
                led_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else if (carga) begin
                // Load wins over a coincident wrap and emits no Tick.
                limite   <= Divisor;
                modo     <= Modo;
                contador <= '0;
                tick_q   <= 1'b0;
                led_q    <= (Modo == M_ON);
            end else begin
                contador <= contador_d;
                tick_q   <= tick_d;
                led_q    <= led_d;
            end
        end

        assign Led[g]  = led_q;
        assign Tick[g] = tick_q;
    end

endmodule

// File: tb/tb_divisor_reloj_multicanal.sv
// Self-checking bench for divisor_reloj_multicanal: directed scenarios
// plus randomized traffic against an arithmetic reference model.

module tb_divisor_reloj_multicanal;

    localparam int CANALES     = 4;
    localparam int ANCHO       = 8;
    localparam int DIV_DEFAULT = 4;
    localparam int SEL_W       = 3;

    logic               clk  = 1'b0;
    logic               rst  = 1'b1;
    logic               hab  = 1'b0;
    logic               carg = 1'b0;
    logic [SEL_W-1:0]   sel  = '0;
    logic [ANCHO-1:0]   div  = '0;
    logic [1:0]         modo = '0;
    logic [CANALES-1:0] led;
    logic [CANALES-1:0] tick;

    int checks   = 0;
    int failures = 0;

    // Model: per channel, enabled cycles since load/reset (n), terminal
    // count, mode, and whether the last edge produced a wrap strobe.
    longint m_n   [CANALES];
    int     m_lim [CANALES];
    int     m_mode[CANALES];
    bit     m_tk  [CANALES];

    always #5 clk = ~clk;

    divisor_reloj_multicanal #(
        .CANALES    (CANALES),
        .ANCHO      (ANCHO),
        .DIV_DEFAULT(DIV_DEFAULT),
        .SEL_W      (SEL_W)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Habilitar  (hab),
        .CargarCanal(carg),
        .SelCanal   (sel),
        .Divisor    (div),
        .Modo       (modo),
        .Led        (led),
        .Tick       (tick)
    );

    task automatic model_reset();
        for (int i = 0; i < CANALES; i++) begin
            m_n[i]    = 0;
            m_lim[i]  = DIV_DEFAULT;
            m_mode[i] = 1;
            m_tk[i]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < CANALES; i++) begin
            if (carg && int'(sel) == i) begin
                m_lim[i]  = int'(div);
                m_mode[i] = int'(modo);
                m_n[i]    = 0;
                m_tk[i]   = 1'b0;
            end else if (hab) begin
                m_n[i]++;
                m_tk[i] = (m_n[i] % (m_lim[i] + 1)) == 0;
            end else begin
                m_tk[i] = 1'b0;
            end
        end
    endtask

    function automatic logic [CANALES-1:0] exp_led();
        logic [CANALES-1:0] r;
        longint p;
        r = '0;
        for (int i = 0; i < CANALES; i++) begin
            p = m_lim[i] + 1;
            case (m_mode[i])
                1:       r[i] = ((m_n[i] / p) % 2) == 1;
                2:       r[i] = (m_n[i] > 0) && (m_n[i] % p == 0);
                3:       r[i] = 1'b1;
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [CANALES-1:0] exp_tick();
        logic [CANALES-1:0] r;
        for (int i = 0; i < CANALES; i++) r[i] = m_tk[i];
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(string tag);
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        chk({tag, " led"}, 32'(led), 32'(exp_led()));
        chk({tag, " tick"}, 32'(tick), 32'(exp_tick()));
    endtask

    task automatic load(int ch, int d, int m);
        carg = 1'b1;
        sel  = SEL_W'(ch);
        div  = ANCHO'(d);
        modo = 2'(m);
        step("load");
        carg = 1'b0;
    endtask

    task automatic wait_tick(string tag, int ch, int budget, output int n);
        n = 0;
        do begin
            step(tag);
            n++;
        end while (!tick[ch] && n <= budget);
    endtask

    task automatic scenario2();
        load(1, 1, 2);
        load(2, 0, 1);
        load(3, 4, 3);
        load(0, 4, 0);
    endtask

    initial begin
        int n;
        model_reset();

        // 1: reset and default toggle
        #12;
        chk("reset led", 32'(led), 32'h0);
        chk("reset tick", 32'(tick), 32'h0);
        rst = 1'b0;
        hab = 1'b1;
        for (int c = 1; c <= 4; c++) step("t1");
        chk("t1 tick c4", 32'(tick), 32'h0);
        step("t1");
        chk("t1 first tick", 32'(tick), 32'hF);
        chk("t1 led on", 32'(led), 32'hF);
        for (int c = 0; c < 5; c++) step("t1");
        chk("t1 led off", 32'(led), 32'h0);
        chk("t1 second tick", 32'(tick), 32'hF);

        // 2: per-channel loads
        scenario2();
        for (int c = 0; c < 12; c++) step("t2");
        chk("t2 ch2 tick high", 32'(tick[2]), 32'h1);
        chk("t2 ch3 led on", 32'(led[3]), 32'h1);
        chk("t2 ch0 led off", 32'(led[0]), 32'h0);

        // 3: freeze at ch0 count 2 and resume
        load(0, 4, 0);
        step("t3");
        step("t3");
        hab = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step("t3 frozen");
            chk("t3 tick low", 32'(tick), 32'h0);
        end
        hab = 1'b1;
        wait_tick("t3 resume", 0, 20, n);
        chk("t3 resume latency", 32'(n), 32'd3);

        // 4: load on the wrap edge
        load(0, 4, 1);
        for (int c = 0; c < 4; c++) step("t4");
        load(0, 3, 1);
        chk("t4 no tick", 32'(tick[0]), 32'h0);
        chk("t4 led low", 32'(led[0]), 32'h0);
        wait_tick("t4 next", 0, 20, n);
        chk("t4 latency", 32'(n), 32'd4);

        // 5: out-of-range select and full-range divisor
        load(5, 0, 3);
        step("t5 ignore");
        load(1, 255, 1);
        wait_tick("t5 p1", 1, 300, n);
        chk("t5 period first", 32'(n), 32'd256);
        wait_tick("t5 p2", 1, 300, n);
        chk("t5 period second", 32'(n), 32'd256);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            hab  = ($urandom % 8) != 0;
            carg = ($urandom % 5) == 0;
            sel  = SEL_W'($urandom % 8);
            div  = (($urandom % 10) == 0) ? 8'd255 : ANCHO'($urandom % 6);
            modo = 2'($urandom % 4);
            step("rnd");
        end
        carg = 1'b0;
        hab  = 1'b1;

        // 6: asynchronous reset in the middle of scenario 2
        scenario2();
        for (int c = 0; c < 3; c++) step("t6 pre");
        chk("t6 ch3 led before", 32'(led[3]), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 async led", 32'(led), 32'h0);
        chk("t6 async tick", 32'(tick), 32'h0);
        model_reset();
        #4;
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) step("t6 replay");
        step("t6 replay");
        chk("t6 first tick", 32'(tick), 32'hF);
        chk("t6 led on", 32'(led), 32'hF);
        for (int c = 0; c < 5; c++) step("t6 replay");
        chk("t6 led off", 32'(led), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
